yc_niu_resp: RTL and testbench
==============================

Name: yc_niu_resp

Overview:
- NoC endpoint responder at mesh node (MY_X, MY_Y).
- Accepts OP_READ_REQ flits on VC_REQ addressed to this node and buffers them in a small FIFO.
- For each request, returns one OP_READ_RSP flit on VC_RSP to the requester after a programmable service latency.
- It is the far end of the yc_noc_defs request initiator. Flit type, field layout, build_flit(), VC_* and OP_* constants all come from yc_noc_defs.

Parameters:
- MY_X, 0, this node's X coordinate, truncated to XW bits.
- MY_Y, 0, this node's Y coordinate, truncated to YW bits.
- REQ_DEPTH, 4, request FIFO entries; power of two, ≥2.
- RSP_LATENCY, 2, cycles held in WAIT before a response is offered; 0 allowed.
- RSP_XOR, 32'h5A5A_5A5A, response data = request data XOR RSP_XOR.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  inbound flit valid.
- rx_flit  in  flit_t  inbound flit.
- rx_ready  out  1  inbound ready; equals !fifo_full.
- tx_valid  out  1  response flit valid.
- tx_flit  out  flit_t  response flit.
- tx_ready  in  1  network accepts the response flit.
- req_count  out  16  valid requests accepted; saturates at 16'hFFFF.
- rsp_count  out  16  responses delivered; saturates at 16'hFFFF.
- err_count  out  16  flits consumed but discarded; saturates at 16'hFFFF.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: tx_valid=0, tx_flit='0, all counters 0, FIFO empty (rx_ready=1), FSM=IDLE, busy=0.
- Reset mid-operation drops all queued and in-flight requests; no partial flit remains valid.
- rx handshake happens on an edge where rx_valid && rx_ready. rx_ready depends only on registered FIFO state, never on rx_valid.
- Classifying an accepted flit:
  - It is a request when op==OP_READ_REQ, vc==VC_REQ, dst_x==MY_X and dst_y==MY_Y.
  - A request is pushed into the FIFO and req_count increments.
  - Any other flit is consumed, not queued, and err_count increments.
- Full FIFO: rx_ready=0, so no flit is consumed, including non-requests.
- Push and pop on the same edge are both allowed. Count is unchanged, and full/empty are computed correctly. Pointers wrap modulo REQ_DEPTH.
- FSM states IDLE, WAIT, SEND:
  - IDLE with FIFO non-empty: pop the head into the holding register.
    - If RSP_LATENCY==0, go to SEND and set tx_valid=1 on the same edge.
    - Otherwise go to WAIT with lat_cnt=0.
  - WAIT: lat_cnt increments each edge. When lat_cnt==RSP_LATENCY-1, go to SEND and set tx_valid=1.
  - SEND: tx_valid and tx_flit stay stable until tx_ready is sampled high. On that edge: tx_valid=0, rsp_count increments, go to IDLE.
  - No back-to-back SEND→SEND; there is at least one IDLE cycle between responses.
- Response flit: build_flit(VC_RSP, OP_READ_RSP, 8'd1, MY_X, MY_Y, req.src_x, req.src_y, req.data ^ RSP_XOR).
  - Source is this node; destination is the requester.
- Latency: with FIFO empty and FSM IDLE, a request accepted at edge E gives tx_valid=1 after edge E+1+RSP_LATENCY.
- Ordering: responses leave strictly in request-acceptance order.
- Counters saturate and never wrap. Simultaneous increment events on different counters are all applied.
- busy is registered-state derived, i.e. (!empty || state!=IDLE).

Test Plan:
- Single request, data 32'hABCD0000, src (0,0), MY=(1,0), RSP_LATENCY=2, tx_ready=1. Required: tx_valid rises 3 edges after acceptance; tx_flit has op=OP_READ_RSP, vc=VC_RSP, dst=(0,0), data=32'hF197_5A5A. Counts: req_count=1, rsp_count=1.
- Backpressure: hold tx_ready=0 and send 5 requests with REQ_DEPTH=4.
  - Required: one request is in SEND and 4 fill the FIFO, so rx_ready=0 and the 6th flit is held.
  - Then release tx_ready. Required: all responses appear in source order with tx_flit stable while stalled, and rsp_count ends at 6.
- Misrouted flit (dst=(2,0)) and an OP_READ_REQ on a wrong VC. Required: both consumed with rx_ready=1, err_count=2, no tx_valid, req_count=0.
- RSP_LATENCY=0 with requests streaming every cycle. Required: a response every 2 cycles, and simultaneous push/pop keeps the FIFO count stable without overflow.
- Assert rst_n low while in WAIT with 2 requests queued. Required: tx_valid=0, counters 0, busy=0, rx_ready=1 immediately. After reset release, a new request is served normally.
- Saturation: preload or force req_count to 16'hFFFE, then send 3 requests. Required: req_count ends at 16'hFFFF.

Source files
------------

// File: rtl/yc_noc_defs.sv
// rtl/yc_noc_defs.sv - shared NoC flit layout, VC/opcode constants and flit builder
package yc_noc_defs;

  localparam int XW = 4;
  localparam int YW = 4;
  localparam int DW = 32;

  localparam logic [1:0] VC_REQ = 2'd0;
  localparam logic [1:0] VC_RSP = 2'd1;

  localparam logic [3:0] OP_READ_REQ  = 4'h1;
  localparam logic [3:0] OP_READ_RSP  = 4'h2;
  localparam logic [3:0] OP_WRITE_REQ = 4'h3;

  typedef struct packed {
    logic [1:0]    vc;
    logic [3:0]    op;
    logic [7:0]    len;
    logic [XW-1:0] src_x;
    logic [YW-1:0] src_y;
    logic [XW-1:0] dst_x;
    logic [YW-1:0] dst_y;
    logic [DW-1:0] data;
  } flit_t;

  function automatic flit_t build_flit(
    input logic [1:0]    vc,
    input logic [3:0]    op,
    input logic [7:0]    len,
    input logic [XW-1:0] src_x,
    input logic [YW-1:0] src_y,
    input logic [XW-1:0] dst_x,
    input logic [YW-1:0] dst_y,
    input logic [DW-1:0] data
  );
    flit_t f;
    f.vc    = vc;
    f.op    = op;
    f.len   = len;
    f.src_x = src_x;
    f.src_y = src_y;
    f.dst_x = dst_x;
    f.dst_y = dst_y;
    f.data  = data;
    return f;
  endfunction

endpackage

// File: rtl/yc_niu_resp.sv
// rtl/yc_niu_resp.sv - NoC endpoint read responder with request FIFO and latency FSM
module yc_niu_resp
  import yc_noc_defs::*;
#(
  parameter int          MY_X        = 0,
  parameter int          MY_Y        = 0,
  parameter int          REQ_DEPTH   = 4,
  parameter int          RSP_LATENCY = 2,
  parameter logic [31:0] RSP_XOR     = 32'h5A5A_5A5A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  flit_t       rx_flit,
  output logic        rx_ready,
  output logic        tx_valid,
  output flit_t       tx_flit,
  input  logic        tx_ready,
  output logic [15:0] req_count,
  output logic [15:0] rsp_count,
  output logic [15:0] err_count,
  output logic        busy
);

  localparam int AW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int CW = $clog2(REQ_DEPTH + 1);
  localparam int LW = (RSP_LATENCY > 1) ? $clog2(RSP_LATENCY) : 1;
  localparam int LAT_M1 = (RSP_LATENCY > 0) ? RSP_LATENCY - 1 : 0;
  localparam logic [LW-1:0] LAT_LAST = LW'(LAT_M1);
  localparam logic [XW-1:0] MY_XL = XW'(MY_X);
  localparam logic [YW-1:0] MY_YL = YW'(MY_Y);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  // Only the requester coordinates and payload are needed to answer a request
  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] data;
  } req_t;

  req_t          mem_q [REQ_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          tx_valid_q, tx_valid_d;
  flit_t         tx_flit_q, tx_flit_d;
  logic [15:0]   req_count_q, req_count_d;
  logic [15:0]   rsp_count_q, rsp_count_d;
  logic [15:0]   err_count_q, err_count_d;

  logic full, empty, accept, is_req, push, pop, rsp_done;
  req_t head, push_data;
  logic unused_len;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  assign unused_len = ^rx_flit.len;

  // Handshake decode, request classification and FIFO pointer/count update
  always_comb begin
    full      = (cnt_q == CW'(REQ_DEPTH));
    empty     = (cnt_q == '0);
    accept    = rx_valid && !full;
    is_req    = (rx_flit.op == OP_READ_REQ) && (rx_flit.vc == VC_REQ) &&
                (rx_flit.dst_x == MY_XL) && (rx_flit.dst_y == MY_YL);
    push      = accept && is_req;
    pop       = (state_q == ST_IDLE) && !empty;
    rsp_done  = tx_valid_q && tx_ready;
    head      = mem_q[rd_ptr_q];
    push_data = '{x: rx_flit.src_x, y: rx_flit.src_y, data: rx_flit.data};
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d     = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Response FSM: pop into the response register, wait out the latency, hold until taken
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    tx_valid_d = tx_valid_q;
    tx_flit_d  = tx_flit_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          tx_flit_d = build_flit(VC_RSP, OP_READ_RSP, 8'd1, MY_XL, MY_YL,
                                 head.x, head.y, head.data ^ RSP_XOR);
          lat_d     = '0;
          if (RSP_LATENCY == 0) begin
            state_d    = ST_SEND;
            tx_valid_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d    = ST_SEND;
          tx_valid_d = 1'b1;
          lat_d      = '0;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // Saturating event counters; independent events on one edge all apply
  always_comb begin
    req_count_d = sat_inc(req_count_q, push);
    err_count_d = sat_inc(err_count_q, accept && !is_req);
    rsp_count_d = sat_inc(rsp_count_q, rsp_done);
  end

  // Request storage; contents are qualified by the count so they need no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // Control state, response register and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
      lat_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_flit_q   <= '0;
      req_count_q <= '0;
      rsp_count_q <= '0;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      lat_q       <= lat_d;
      tx_valid_q  <= tx_valid_d;
      tx_flit_q   <= tx_flit_d;
      req_count_q <= req_count_d;
      rsp_count_q <= rsp_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign rx_ready  = !full;
  assign tx_valid  = tx_valid_q;
  assign tx_flit   = tx_flit_q;
  assign req_count = req_count_q;
  assign rsp_count = rsp_count_q;
  assign err_count = err_count_q;
  assign busy      = !empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_yc_niu_resp.sv
// tb/tb_yc_niu_resp.sv - directed self-checking bench for yc_niu_resp
module tb_yc_niu_resp;
  import yc_noc_defs::*;

  localparam logic [31:0] XOR_K = 32'h5A5A_5A5A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        rx_valid0 = 1'b0, rx_ready0, tx_valid0, tx_ready0 = 1'b0, busy0;
  flit_t       rx_flit0 = '0, tx_flit0;
  logic [15:0] req_count0, rsp_count0, err_count0;

  logic        rx_valid1 = 1'b0, rx_ready1, tx_valid1, tx_ready1 = 1'b0, busy1;
  flit_t       rx_flit1 = '0, tx_flit1;
  logic [15:0] req_count1, rsp_count1, err_count1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  yc_niu_resp #(.MY_X(1), .MY_Y(0), .REQ_DEPTH(4), .RSP_LATENCY(2), .RSP_XOR(XOR_K)) u0 (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid0), .rx_flit(rx_flit0), .rx_ready(rx_ready0),
    .tx_valid(tx_valid0), .tx_flit(tx_flit0), .tx_ready(tx_ready0),
    .req_count(req_count0), .rsp_count(rsp_count0), .err_count(err_count0),
    .busy(busy0)
  );

  yc_niu_resp #(.MY_X(1), .MY_Y(0), .REQ_DEPTH(4), .RSP_LATENCY(0), .RSP_XOR(XOR_K)) u1 (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid1), .rx_flit(rx_flit1), .rx_ready(rx_ready1),
    .tx_valid(tx_valid1), .tx_flit(tx_flit1), .tx_ready(tx_ready1),
    .req_count(req_count1), .rsp_count(rsp_count1), .err_count(err_count1),
    .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic flit_t req_flit(input logic [3:0] sx, input logic [3:0] sy, input logic [31:0] d);
    return build_flit(VC_REQ, OP_READ_REQ, 8'd1, sx, sy, 4'd1, 4'd0, d);
  endfunction

  task automatic do_reset();
    rx_valid0 = 1'b0; rx_valid1 = 1'b0;
    tx_ready0 = 1'b0; tx_ready1 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send0(input flit_t f);
    int g = 0;
    rx_valid0 = 1'b1;
    rx_flit0  = f;
    while (!rx_ready0 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (!rx_ready0) check("send0_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    rx_valid0 = 1'b0;
  endtask

  initial begin
    flit_t f;
    flit_t held;
    int idx, got, sent, last, seen_tx;
    logic acc;

    // Reset state
    do_reset();
    check("rst_tx_valid", tx_valid0, 0);
    check("rst_tx_flit", tx_flit0[31:0], 0);
    check("rst_rx_ready", rx_ready0, 1);
    check("rst_busy", busy0, 0);
    check("rst_counts", {req_count0, rsp_count0 | err_count0}, 0);

    // Single request, latency 2
    tx_ready0 = 1'b1;
    send0(req_flit(4'd0, 4'd0, 32'hABCD_0000));
    check("t1_e0_valid", tx_valid0, 0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("t1_e%0d_valid", k), tx_valid0, (k == 3) ? 1 : 0);
    end
    check("t1_busy", busy0, 1);
    check("t1_op", tx_flit0.op, OP_READ_RSP);
    check("t1_vc", tx_flit0.vc, VC_RSP);
    check("t1_src", {tx_flit0.src_x, tx_flit0.src_y}, 8'h10);
    check("t1_dst", {tx_flit0.dst_x, tx_flit0.dst_y}, 8'h00);
    check("t1_data", tx_flit0.data, 32'hF197_5A5A);
    @(posedge clk); #1;
    check("t1_valid_drop", tx_valid0, 0);
    check("t1_req_count", req_count0, 1);
    check("t1_rsp_count", rsp_count0, 1);

    // Backpressure: 5 requests fill SEND + FIFO, 6th is held
    do_reset();
    for (int i = 0; i < 5; i++) send0(req_flit(4'(i), 4'd0, 32'h100 + i));
    check("t2_full_ready", rx_ready0, 0);
    rx_valid0 = 1'b1;
    rx_flit0  = req_flit(4'd5, 4'd0, 32'h105);
    held = tx_flit0;
    repeat (3) begin @(posedge clk); #1; end
    check("t2_held_ready", rx_ready0, 0);
    check("t2_req_held", req_count0, 5);
    check("t2_tx_valid_stall", tx_valid0, 1);
    check("t2_stable_dst", tx_flit0.dst_x, held.dst_x);
    check("t2_stable_data", tx_flit0.data, held.data);
    check("t2_first_dst", held.dst_x, 0);
    tx_ready0 = 1'b1;
    idx = 0;
    for (int c = 0; c < 80 && idx < 6; c++) begin
      acc = rx_valid0 && rx_ready0;
      if (tx_valid0) begin
        check($sformatf("t2_order_dst%0d", idx), tx_flit0.dst_x, idx);
        check($sformatf("t2_order_data%0d", idx), tx_flit0.data, (32'h100 + idx) ^ XOR_K);
        idx++;
      end
      @(posedge clk); #1;
      if (acc) rx_valid0 = 1'b0;
    end
    check("t2_all_rsp_seen", idx, 6);
    check("t2_rsp_count", rsp_count0, 6);
    check("t2_req_count", req_count0, 6);

    // Misrouted and wrong-VC flits are consumed and counted as errors
    do_reset();
    tx_ready0 = 1'b1;
    check("t3_ready_a", rx_ready0, 1);
    send0(build_flit(VC_REQ, OP_READ_REQ, 8'd1, 4'd0, 4'd0, 4'd2, 4'd0, 32'h1));
    check("t3_ready_b", rx_ready0, 1);
    send0(build_flit(VC_RSP, OP_READ_REQ, 8'd1, 4'd0, 4'd0, 4'd1, 4'd0, 32'h2));
    seen_tx = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (tx_valid0) seen_tx = 1;
    end
    check("t3_no_tx", seen_tx, 0);
    check("t3_err_count", err_count0, 2);
    check("t3_req_count", req_count0, 0);
    check("t3_busy", busy0, 0);

    // Latency 0 with requests every cycle: one response per 2 cycles, in order
    do_reset();
    tx_ready1 = 1'b1;
    rx_valid1 = 1'b1;
    rx_flit1  = req_flit(4'd0, 4'd2, 32'h200);
    sent = 0; got = 0; last = -1;
    for (int c = 0; c < 80 && got < 8; c++) begin
      acc = rx_valid1 && rx_ready1;
      if (tx_valid1) begin
        check($sformatf("t4_data%0d", got), tx_flit1.data, (32'h200 + got) ^ XOR_K);
        if (last >= 0) check($sformatf("t4_gap%0d", got), c - last, 2);
        last = c;
        got++;
      end
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 8) rx_flit1 = req_flit(4'(sent), 4'd2, 32'h200 + sent);
        else rx_valid1 = 1'b0;
      end
    end
    check("t4_rsp_seen", got, 8);
    check("t4_req_count", req_count1, 8);
    check("t4_rsp_count", rsp_count1, 8);
    check("t4_busy_end", busy1, 0);

    // Reset while in WAIT with two queued
    do_reset();
    tx_ready0 = 1'b1;
    for (int i = 0; i < 3; i++) send0(req_flit(4'(i), 4'd1, 32'h300 + i));
    check("t5_busy_pre", busy0, 1);
    check("t5_tx_pre", tx_valid0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_tx_valid", tx_valid0, 0);
    check("t5_rst_counts", {req_count0, rsp_count0}, 0);
    check("t5_rst_busy", busy0, 0);
    check("t5_rst_ready", rx_ready0, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    send0(req_flit(4'd3, 4'd3, 32'h1234_5678));
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("t5_e%0d_valid", k), tx_valid0, (k == 3) ? 1 : 0);
    end
    check("t5_dst", {tx_flit0.dst_x, tx_flit0.dst_y}, 8'h33);
    check("t5_data", tx_flit0.data, 32'h486E_0C22);
    @(posedge clk); #1;
    check("t5_rsp_count", rsp_count0, 1);

    // Saturation of req_count
    do_reset();
    tx_ready0 = 1'b1;
    force u0.req_count_q = 16'hFFFE;
    @(posedge clk); #1;
    release u0.req_count_q;
    #1;
    check("t6_preload", req_count0, 16'hFFFE);
    send0(req_flit(4'd0, 4'd0, 32'h0));
    check("t6_after1", req_count0, 16'hFFFF);
    send0(req_flit(4'd0, 4'd0, 32'h1));
    send0(req_flit(4'd0, 4'd0, 32'h2));
    check("t6_saturated", req_count0, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
